// File: rtl/dac714_pkg.sv
// Shared state encoding, default parameters and DAC714 interface timing minima
// for the DAC714 serial transmitter.
package dac714_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StLatch = 2'd2
    } dac_state_e;

    localparam int unsigned DEF_DAC_WIDTH   = 16;
    localparam int unsigned DEF_CLK_DIV     = 2;
    localparam int unsigned DEF_LDAC_CYCLES = 2;

    // DAC714 minimum interface timing in ns; clk_slow runs at 10 MHz.
    localparam int unsigned CLK_SLOW_PERIOD_NS = 100;
    localparam int unsigned T_SCLK_PW_MIN_NS   = 50;
    localparam int unsigned T_SDI_SETUP_MIN_NS = 25;
    localparam int unsigned T_SDI_HOLD_MIN_NS  = 10;
    localparam int unsigned T_LDAC_PW_MIN_NS   = 50;

    function automatic int unsigned cycles_to_ns(input int unsigned cycles);
        return cycles * CLK_SLOW_PERIOD_NS;
    endfunction

endpackage

// File: rtl/dac714_sclk_gen.sv
// SCLK divider: toggles sclk every CLK_DIV clk_slow cycles while enabled and
// flags the cycle on which the next edge is a rise or a fall.
module dac714_sclk_gen
    import dac714_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk_slow,
    input  logic nReset,
    input  logic en,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt_q, div_cnt_d;
    logic       sclk_q, sclk_d;
    logic       terminal;

    assign terminal = en && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d = div_cnt_q;
        sclk_d    = sclk_q;
        if (!en) begin
            // Disabled: park the divider so the next frame starts from a clean phase.
            div_cnt_d = 8'd0;
            sclk_d    = 1'b0;
        end else if (terminal) begin
            div_cnt_d = 8'd0;
            sclk_d    = ~sclk_q;
        end else begin
            div_cnt_d = div_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            div_cnt_q <= 8'd0;
            sclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            sclk_q    <= sclk_d;
        end
    end

    assign sclk      = sclk_q;
    assign rise_tick = terminal & ~sclk_q;
    assign fall_tick = terminal & sclk_q;

endmodule

// File: rtl/dac714_serial_tx.sv
// Serialises ramp-generator samples MSB-first onto the DAC714 three-wire bus,
// with a one-deep pending buffer for strobes that arrive mid-frame.
module dac714_serial_tx
    import dac714_pkg::*;
#(
    parameter int unsigned DAC_WIDTH   = DEF_DAC_WIDTH,
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned LDAC_CYCLES = DEF_LDAC_CYCLES
) (
    input  logic                        clk_slow,
    input  logic                        nReset,
    input  logic                        strobe,
    input  logic signed [DAC_WIDTH-1:0] data,
    output logic                        dac_sclk,
    output logic                        dac_sdi,
    output logic                        dac_ncs,
    output logic                        dac_nldac,
    output logic                        busy,
    output logic                        overrun
);

    localparam int unsigned          BIT_CNT_W = $clog2(DAC_WIDTH) + 1;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DAC_WIDTH - 1);
    localparam logic [3:0]           LDAC_LAST = 4'(LDAC_CYCLES - 1);

    dac_state_e           state_q, state_d;
    logic [DAC_WIDTH-1:0] shreg_q, shreg_d;
    logic [DAC_WIDTH-1:0] pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic                 strobe_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]           ldac_cnt_q, ldac_cnt_d;
    logic                 setup_q, setup_d;
    logic                 ncs_q, ncs_d;
    logic                 sdi_q, sdi_d;
    logic                 nldac_q, nldac_d;
    logic                 overrun_q, overrun_d;

    logic                 start;
    logic                 do_load;
    logic [DAC_WIDTH-1:0] load_word;
    logic                 sclk_en;
    logic                 rise_tick;
    logic                 fall_tick;

    assign start     = strobe & ~strobe_q;
    // A pending word always goes ahead of a fresh strobe.
    assign load_word = pend_valid_q ? pend_q : data;
    assign do_load   = (state_q == StIdle) && (pend_valid_q || start);
    // SCLK is held off for the first SHIFT cycle so SDI sets up for a full half-period.
    assign sclk_en   = (state_q == StShift) && !setup_q;

    dac714_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_slow  (clk_slow),
        .nReset    (nReset),
        .en        (sclk_en),
        .sclk      (dac_sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        bit_cnt_d    = bit_cnt_q;
        ldac_cnt_d   = ldac_cnt_q;
        setup_d      = setup_q;
        ncs_d        = ncs_q;
        sdi_d        = sdi_q;
        nldac_d      = nldac_q;
        overrun_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (do_load) begin
                    shreg_d      = load_word;
                    sdi_d        = load_word[DAC_WIDTH-1];
                    ncs_d        = 1'b0;
                    bit_cnt_d    = '0;
                    setup_d      = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = StShift;
                end
                // Strobe landing while the pending word is consumed is queued behind it.
                if (pend_valid_q && start) begin
                    pend_d       = data;
                    pend_valid_d = 1'b1;
                end
            end
            StShift: begin
                setup_d = 1'b0;
                if (fall_tick) begin
                    shreg_d   = shreg_q << 1;
                    sdi_d     = shreg_q[DAC_WIDTH-2];
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_LAST) begin
                        ncs_d      = 1'b1;
                        sdi_d      = 1'b0;
                        nldac_d    = 1'b0;
                        ldac_cnt_d = 4'd0;
                        state_d    = StLatch;
                    end
                end
            end
            StLatch: begin
                if (ldac_cnt_q == LDAC_LAST) begin
                    nldac_d    = 1'b1;
                    ldac_cnt_d = 4'd0;
                    state_d    = StIdle;
                end else begin
                    ldac_cnt_d = ldac_cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Busy-case strobe: newest sample wins the pending slot.
        if (start && (state_q != StIdle)) begin
            overrun_d    = pend_valid_q;
            pend_d       = data;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk_slow) begin
        if (!nReset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            strobe_q     <= 1'b0;
            bit_cnt_q    <= '0;
            ldac_cnt_q   <= 4'd0;
            setup_q      <= 1'b0;
            ncs_q        <= 1'b1;
            sdi_q        <= 1'b0;
            nldac_q      <= 1'b1;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            strobe_q     <= strobe;
            bit_cnt_q    <= bit_cnt_d;
            ldac_cnt_q   <= ldac_cnt_d;
            setup_q      <= setup_d;
            ncs_q        <= ncs_d;
            sdi_q        <= sdi_d;
            nldac_q      <= nldac_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dac_ncs   = ncs_q;
    assign dac_sdi   = sdi_q;
    assign dac_nldac = nldac_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle) || pend_valid_q;

    // Parameter legality and DAC714 timing minima at the chosen divider settings.
    assert property (@(posedge clk_slow) (CLK_DIV >= 1) && (CLK_DIV <= 255));
    assert property (@(posedge clk_slow) (LDAC_CYCLES >= 1) && (LDAC_CYCLES <= 15));
    assert property (@(posedge clk_slow) cycles_to_ns(CLK_DIV) >= T_SCLK_PW_MIN_NS);
    assert property (@(posedge clk_slow) cycles_to_ns(CLK_DIV) >= T_SDI_SETUP_MIN_NS);
    assert property (@(posedge clk_slow) cycles_to_ns(CLK_DIV) >= T_SDI_HOLD_MIN_NS);
    assert property (@(posedge clk_slow) cycles_to_ns(LDAC_CYCLES) >= T_LDAC_PW_MIN_NS);

    // Bus protocol invariants.
    assert property (@(posedge clk_slow) disable iff (!nReset)
        $rose(dac_sclk) |-> $stable(dac_sdi));
    assert property (@(posedge clk_slow) disable iff (!nReset)
        !dac_nldac |-> dac_ncs);
    assert property (@(posedge clk_slow) disable iff (!nReset)
        rise_tick |-> (state_q == StShift) && !dac_ncs);
    assert property (@(posedge clk_slow) disable iff (!nReset)
        dac_ncs |-> !dac_sclk && !dac_sdi);

endmodule
